// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter (dmem_arbiter).
package dmem_arb_pkg;

    localparam int DW_DEF   = 8;
    localparam int AW_DEF   = 8;
    localparam int STAT_W   = 16;
    // Wide enough for the largest legal STARVE_LIMIT (15)
    localparam int STARVE_W = 4;

    typedef enum logic [1:0] {
        ARB_CPU   = 2'd0,
        ARB_WAIT  = 2'd1,
        ARB_FORCE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/arb_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module arb_sat_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] CNT_MAX = '1;

    // Count up on inc, stop at CNT_MAX, clear has priority
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (inc && (cnt != CNT_MAX)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: the MEM-stage CPU port has fixed priority over the
// aux (loader/debug) valid/ready port; a starvation counter forces an aux
// grant and stalls the pipeline for one cycle when aux has waited too long.
// Optional build macro ARB_STATS_EN adds saturating stall/aux-grant counters;
// without it stat_stalls/stat_aux are tied to zero and no counter flops exist.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DW           = DW_DEF,
    parameter int AW           = AW_DEF,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [AW-1:0]     cpu_addr,
    input  logic [DW-1:0]     cpu_wdata,
    output logic [DW-1:0]     cpu_rdata,
    output logic              cpu_stall,
    input  logic              aux_valid,
    input  logic              aux_we,
    input  logic [AW-1:0]     aux_addr,
    input  logic [DW-1:0]     aux_wdata,
    output logic              aux_ready,
    output logic              aux_rvalid,
    output logic [DW-1:0]     aux_rdata,
    output logic              mem_re,
    output logic              mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_wdata,
    input  logic [DW-1:0]     mem_rdata,
    output logic [STAT_W-1:0] stat_stalls,
    output logic [STAT_W-1:0] stat_aux
);

    localparam logic [STARVE_W-1:0] LIMIT_V = STARVE_W'(STARVE_LIMIT);

    arb_state_t          state;
    arb_state_t          state_nxt;
    logic [STARVE_W-1:0] starve_cnt;
    logic [STARVE_W-1:0] starve_inc;
    logic                cpu_req;
    logic                grant_aux;
    logic                grant_cpu;
    logic                aux_blocked;
    logic                aux_rd_acc;
    logic                rvld_p1;
    logic [DW-1:0]       rdata_p1;

    // Grant decision and memory port steering for the current cycle
    always_comb begin
        cpu_req     = cpu_rd | cpu_wr;
        grant_aux   = aux_valid & ((state == ARB_FORCE) | ~cpu_req);
        grant_cpu   = cpu_req & ~grant_aux;
        aux_blocked = aux_valid & ~grant_aux;
        aux_rd_acc  = grant_aux & ~aux_we;
        cpu_stall   = (state == ARB_FORCE) & aux_valid & cpu_req;
        aux_ready   = grant_aux;
        mem_re      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = cpu_addr;
        mem_wdata   = cpu_wdata;
        if (grant_aux) begin
            mem_re    = ~aux_we;
            mem_we    = aux_we;
            mem_addr  = aux_addr;
            mem_wdata = aux_wdata;
        end else if (grant_cpu) begin
            // A simultaneous rd+wr is resolved as a store
            mem_re = cpu_rd & ~cpu_wr;
            mem_we = cpu_wr;
        end
    end

    // Next state: ARB_CPU holds starve_cnt at 0, so +1 covers both entry and counting
    always_comb begin
        starve_inc = starve_cnt + 1'b1;
        state_nxt  = ARB_CPU;
        if (aux_blocked) begin
            state_nxt = (starve_inc == LIMIT_V) ? ARB_FORCE : ARB_WAIT;
        end
    end

    // Consecutive blocked cycles of the aux request; any grant or withdrawal restarts it
    arb_sat_counter #(.W(STARVE_W)) u_starve (
        .clk   (clk),
        .reset (reset),
        .clear (~aux_blocked),
        .inc   (aux_blocked),
        .cnt   (starve_cnt)
    );

    // Arbitration state plus the one-cycle aux read return
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ARB_CPU;
            rvld_p1  <= 1'b0;
            rdata_p1 <= '0;
        end else begin
            state   <= state_nxt;
            rvld_p1 <= aux_rd_acc;
            if (aux_rd_acc) begin
                rdata_p1 <= mem_rdata;
            end
        end
    end

    assign aux_rvalid = rvld_p1;
    assign aux_rdata  = rdata_p1;
    assign cpu_rdata  = mem_rdata;

`ifdef ARB_STATS_EN
    arb_sat_counter #(.W(STAT_W)) u_stat_stalls (
        .clk   (clk),
        .reset (reset),
        .clear (1'b0),
        .inc   (cpu_stall),
        .cnt   (stat_stalls)
    );

    arb_sat_counter #(.W(STAT_W)) u_stat_aux (
        .clk   (clk),
        .reset (reset),
        .clear (1'b0),
        .inc   (grant_aux),
        .cnt   (stat_aux)
    );
`else
    assign stat_stalls = '0;
    assign stat_aux    = '0;
`endif

    // A load and a store from the MEM stage in the same cycle is a pipeline bug
    assert property (@(posedge clk) disable iff (reset) !(cpu_rd && cpu_wr));

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a driver issues stimulus and pushes
// the expected response from a cycle-level reference model; a monitor on
// the falling edge pops and compares.
module tb_dmem_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_rd, cpu_wr;
    logic [7:0]  cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        aux_valid, aux_we;
    logic [7:0]  aux_addr, aux_wdata;
    logic        aux_ready, aux_rvalid;
    logic [7:0]  aux_rdata;
    logic        mem_re, mem_we;
    logic [7:0]  mem_addr, mem_wdata, mem_rdata;
    logic [15:0] stat_stalls, stat_aux;

    logic [7:0]  mem     [256] = '{default: 8'h00};
    logic [7:0]  ref_mem [256] = '{default: 8'h00};

    typedef struct {
        logic        aux_ready;
        logic        cpu_stall;
        logic        mem_re;
        logic        mem_we;
        logic        rvalid;
        logic        chk_crd;
        logic [7:0]  addr;
        logic [7:0]  wdata;
        logic [7:0]  crd;
        logic [15:0] st_stall;
        logic [15:0] st_aux;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] rd_q[$];
    exp_t       mon_e;

    int blocked  = 0;
    bit prev_rd  = 1'b0;
    int m_stalls = 0;
    int m_aux    = 0;
    int n_checks = 0;
    int n_pass   = 0;

    dmem_arbiter #(.DW(8), .AW(8), .STARVE_LIMIT(LIMIT)) dut (
        .clk         (clk),
        .reset       (reset),
        .cpu_rd      (cpu_rd),
        .cpu_wr      (cpu_wr),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_rdata   (cpu_rdata),
        .cpu_stall   (cpu_stall),
        .aux_valid   (aux_valid),
        .aux_we      (aux_we),
        .aux_addr    (aux_addr),
        .aux_wdata   (aux_wdata),
        .aux_ready   (aux_ready),
        .aux_rvalid  (aux_rvalid),
        .aux_rdata   (aux_rdata),
        .mem_re      (mem_re),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .stat_stalls (stat_stalls),
        .stat_aux    (stat_aux)
    );

    always #5 clk = ~clk;

    // Single-port memory with combinational read
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, want, $time);
    endtask

    task automatic model_reset();
        blocked  = 0;
        prev_rd  = 1'b0;
        m_stalls = 0;
        m_aux    = 0;
        rd_q.delete();
    endtask

    task automatic set_idle();
        cpu_rd = 0; cpu_wr = 0; cpu_addr = 0; cpu_wdata = 0;
        aux_valid = 0; aux_we = 0; aux_addr = 0; aux_wdata = 0;
    endtask

    // One cycle of stimulus; the model says: aux wins when the CPU is idle or
    // when aux has already been refused LIMIT cycles in a row.
    task automatic drive(input logic rd, input logic wr, input logic [7:0] ca, input logic [7:0] cw,
                         input logic av, input logic awe, input logic [7:0] aa, input logic [7:0] aw,
                         output logic granted);
        exp_t e;
        logic creq, ga, gc;
        @(posedge clk); #1;
        cpu_rd = rd; cpu_wr = wr; cpu_addr = ca; cpu_wdata = cw;
        aux_valid = av; aux_we = awe; aux_addr = aa; aux_wdata = aw;
        creq = rd | wr;
        ga   = av && (!creq || blocked >= LIMIT);
        gc   = creq && !ga;
        e.aux_ready = ga;
        e.cpu_stall = ga && creq;
        e.mem_re    = gc ? (rd && !wr) : (ga ? !awe : 1'b0);
        e.mem_we    = gc ? wr : (ga ? awe : 1'b0);
        e.addr      = ga ? aa : ca;
        e.wdata     = ga ? aw : cw;
        e.rvalid    = prev_rd;
        e.chk_crd   = gc && rd && !wr;
        e.crd       = ref_mem[ca];
`ifdef ARB_STATS_EN
        e.st_stall  = 16'(m_stalls);
        e.st_aux    = 16'(m_aux);
`else
        e.st_stall  = 16'h0;
        e.st_aux    = 16'h0;
`endif
        exp_q.push_back(e);
        if (ga && !awe) rd_q.push_back(ref_mem[aa]);
        if (e.mem_we) ref_mem[e.addr] = e.wdata;
        prev_rd = ga && !awe;
        blocked = (av && !ga) ? blocked + 1 : 0;
        if (e.cpu_stall && m_stalls < 65535) m_stalls++;
        if (ga && m_aux < 65535) m_aux++;
        granted = ga;
    endtask

    task automatic idle_cycle();
        logic g;
        drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, g);
    endtask

    // Store stream at 0x60 with aux write pending: LIMIT refusals, then a forced grant
    task automatic forced_burst(input logic [7:0] base);
        logic g;
        for (int k = 0; k <= LIMIT; k++) drive(0, 1, 8'h60, base + 8'(k), 1, 1, 8'h61, base, g);
        drive(0, 1, 8'h60, base + 8'(LIMIT), 0, 0, 8'h00, 8'h00, g);
    endtask

    // Monitor: compare whatever the DUT presents against the oldest expectation
    always @(negedge clk) begin
        if (!reset && exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("aux_ready", 32'(aux_ready), 32'(mon_e.aux_ready));
            chk("cpu_stall", 32'(cpu_stall), 32'(mon_e.cpu_stall));
            chk("mem_re", 32'(mem_re), 32'(mon_e.mem_re));
            chk("mem_we", 32'(mem_we), 32'(mon_e.mem_we));
            chk("mem_addr", 32'(mem_addr), 32'(mon_e.addr));
            chk("mem_wdata", 32'(mem_wdata), 32'(mon_e.wdata));
            chk("aux_rvalid", 32'(aux_rvalid), 32'(mon_e.rvalid));
            chk("stat_stalls", 32'(stat_stalls), 32'(mon_e.st_stall));
            chk("stat_aux", 32'(stat_aux), 32'(mon_e.st_aux));
            if (mon_e.chk_crd) chk("cpu_rdata", 32'(cpu_rdata), 32'(mon_e.crd));
            if (mon_e.rvalid && aux_rvalid) begin
                if (rd_q.size() > 0) chk("aux_rdata", 32'(aux_rdata), 32'(rd_q.pop_front()));
                else chk("aux_rdata_unexpected", 32'(1), 32'(0));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got %0d checks, expected completion", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic       g;
        logic       r_av, r_awe, r_rd, r_wr;
        logic [7:0] r_aa, r_aw, r_ca, r_cw;
        int         op;

        set_idle();
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_aux_rvalid", 32'(aux_rvalid), 0);
        chk("rst_aux_rdata", 32'(aux_rdata), 0);
        chk("rst_cpu_stall", 32'(cpu_stall), 0);
        chk("rst_aux_ready", 32'(aux_ready), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_stat_stalls", 32'(stat_stalls), 0);
        chk("rst_stat_aux", 32'(stat_aux), 0);
        @(negedge clk);
        reset = 0;

        // Aux write then read-back while the CPU is idle
        drive(0, 0, 8'h00, 8'h00, 1, 1, 8'h10, 8'hA5, g);
        drive(0, 0, 8'h00, 8'h00, 1, 0, 8'h10, 8'h00, g);
        idle_cycle();
        #1;
        chk("aux_rdata_A5", 32'(aux_rdata), 'hA5);

        // CPU store every cycle with aux write held: four refusals, then forced grant
        for (int k = 0; k < 5; k++) drive(0, 1, 8'h30, 8'h70 + 8'(k), 1, 1, 8'h31, 8'hC3, g);
        drive(0, 1, 8'h30, 8'h74, 0, 0, 8'h00, 8'h00, g);
        idle_cycle();
        chk("mem_30_retried_store", 32'(mem[8'h30]), 'h74);
        chk("mem_31_aux_store", 32'(mem[8'h31]), 'hC3);

        // Simultaneous CPU load and aux read: CPU wins
        drive(1, 0, 8'h20, 8'h00, 1, 0, 8'h21, 8'h00, g);
        idle_cycle();

        // Aux withdrawn after two refusals, then reasserted: starvation count restarts
        drive(0, 1, 8'h40, 8'h01, 1, 0, 8'h41, 8'h00, g);
        drive(0, 1, 8'h40, 8'h02, 1, 0, 8'h41, 8'h00, g);
        drive(0, 1, 8'h40, 8'h03, 0, 0, 8'h00, 8'h00, g);
        for (int k = 0; k < 5; k++) drive(0, 1, 8'h40, 8'h04 + 8'(k), 1, 0, 8'h41, 8'h00, g);
        drive(0, 1, 8'h40, 8'h08, 0, 0, 8'h00, 8'h00, g);
        idle_cycle();

        // Asynchronous reset right after an accepted aux read drops the return
        drive(0, 0, 8'h00, 8'h00, 1, 0, 8'h10, 8'h00, g);
        @(posedge clk); #1;
        set_idle();
        chk("rvalid_before_reset", 32'(aux_rvalid), 1);
        chk("rdata_before_reset", 32'(aux_rdata), 'hA5);
        reset = 1; #1;
        chk("rvalid_async_reset", 32'(aux_rvalid), 0);
        chk("rdata_async_reset", 32'(aux_rdata), 0);
        model_reset();
        @(negedge clk);
        reset = 0;

        // Asynchronous reset with a forced grant pending discards it
        for (int k = 0; k < LIMIT; k++) drive(0, 1, 8'h50, 8'h11, 1, 1, 8'h51, 8'h22, g);
        @(posedge clk); #1;
        chk("force_ready_pre", 32'(aux_ready), 1);
        chk("force_stall_pre", 32'(cpu_stall), 1);
        reset = 1; #1;
        chk("force_ready_reset", 32'(aux_ready), 0);
        chk("force_stall_reset", 32'(cpu_stall), 0);
        chk("force_addr_reset", 32'(mem_addr), 'h50);
        set_idle();
        model_reset();
        @(negedge clk);
        reset = 0;

        // Three forced grants, then saturation of the stall counter
        forced_burst(8'h80);
        forced_burst(8'h90);
        forced_burst(8'hA0);
        idle_cycle();
`ifdef ARB_STATS_EN
        chk("stat_stalls_3", 32'(stat_stalls), 3);
        chk("stat_aux_3", 32'(stat_aux), 3);
        @(negedge clk); #1;
        force dut.u_stat_stalls.cnt = 16'hFFFF;
        #1;
        release dut.u_stat_stalls.cnt;
        m_stalls = 65535;
        forced_burst(8'hB0);
        idle_cycle();
        chk("stat_stalls_sat", 32'(stat_stalls), 'hFFFF);
        chk("stat_aux_4", 32'(stat_aux), 4);
`endif

        // Randomized traffic; aux mostly holds its request until accepted
        r_av = 0; r_awe = 0; r_aa = 0; r_aw = 0;
        g = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            op   = int'($urandom_range(0, 7));
            r_rd = (op == 1) || (op == 2) || (op == 3);
            r_wr = (op >= 4) && (op <= 6);
            r_ca = 8'($urandom_range(0, 15));
            r_cw = 8'($urandom);
            if (g || !r_av || $urandom_range(0, 9) == 0) begin
                r_av  = $urandom_range(0, 2) != 0;
                r_awe = 1'($urandom_range(0, 1));
                r_aa  = 8'($urandom_range(0, 15));
                r_aw  = 8'($urandom);
            end
            drive(r_rd, r_wr, r_ca, r_cw, r_av, r_awe, r_aa, r_aw, g);
        end
        idle_cycle();
        idle_cycle();

        @(negedge clk); #1;
        chk("exp_q_drained", 32'(exp_q.size()), 0);
        chk("rd_q_drained", 32'(rd_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port 8-bit data memory between two requesters:
  - the pipeline MEM stage (CPU port, primary);
  - an auxiliary valid/ready port used by the program/debug loader.
- The CPU has fixed priority, bounded by a starvation counter. When the counter expires, the aux port gets a forced grant and the pipeline is stalled for one cycle.
- Sits between the MEM stage and the data memory. Drives the memory's read/write strobes, address and write data.

Parameters:
- DW, 8, data width
- AW, 8, address width (memory addressed by ALU result)
- STARVE_LIMIT, 4, consecutive cycles aux may wait before a forced grant; legal range 1..15

Ports:
- clk  in  1  clock
- reset  in  1  async active-high reset
- cpu_rd  in  1  MEM-stage load
- cpu_wr  in  1  MEM-stage store
- cpu_addr  in  AW  MEM-stage address
- cpu_wdata  in  DW  MEM-stage store data
- cpu_rdata  out  DW  load data to MEM stage (combinational pass of mem_rdata)
- cpu_stall  out  1  freeze IF/ID/EX/MEM this cycle; CPU access not performed
- aux_valid  in  1  aux request pending
- aux_we  in  1  1 = write, 0 = read
- aux_addr  in  AW  aux address
- aux_wdata  in  DW  aux write data
- aux_ready  out  1  aux request accepted this cycle
- aux_rvalid  out  1  aux read data valid
- aux_rdata  out  DW  aux read data
- mem_re  out  1  memory read strobe
- mem_we  out  1  memory write strobe
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data (combinational read)
- stat_stalls  out  16  stall-cycle count (ARB_STATS_EN)
- stat_aux  out  16  aux grant count (ARB_STATS_EN)

Behaviour:
- Reset (async, active-high; clock clk):
  - state = ARB_CPU; starve_cnt = 0.
  - aux_rvalid = 0; aux_rdata = 0; stat counters = 0.
  - Combinational outputs follow from the reset state.
- cpu_req = cpu_rd | cpu_wr. cpu_rd & cpu_wr together is illegal; the CPU is treated as a write (assertion in sim).
- FSM state register:
  - ARB_CPU: CPU priority, aux not waiting.
  - ARB_WAIT: aux waiting, starve_cnt counting.
  - ARB_FORCE: aux granted regardless of CPU.
- Grant (combinational from state and inputs):
  - ARB_FORCE & aux_valid → grant aux; cpu_stall = cpu_req.
  - Otherwise, cpu_req → grant CPU; aux_ready = 0.
  - Otherwise, aux_valid → grant aux.
  - Otherwise, no grant: mem_re = mem_we = 0; mem_addr/mem_wdata = cpu values.
- Memory drive:
  - CPU grant: mem_re = cpu_rd & ~cpu_wr, mem_we = cpu_wr, address/data from the cpu port.
  - Aux grant: mem_re = ~aux_we, mem_we = aux_we, address/data from the aux port; aux_ready = 1.
- Stall rules: cpu_stall is only ever 1 in ARB_FORCE. The held MEM instruction retries the next cycle.
- Transitions (registered):
  - Aux handshake (aux_valid & aux_ready): next state ARB_CPU, starve_cnt = 0.
  - ARB_CPU & aux_valid & ~aux_ready: if STARVE_LIMIT = 1 go to ARB_FORCE; else go to ARB_WAIT with starve_cnt = 1.
  - ARB_WAIT & aux_valid & ~aux_ready: starve_cnt + 1; enter ARB_FORCE when the new value equals STARVE_LIMIT.
  - aux_valid = 0 in any state: ARB_CPU, starve_cnt = 0 (aux withdrawal legal, not a protocol error).
  - ARB_FORCE always resolves in one cycle, since aux_valid is either granted or dropped.
- Aux read latency: 1 cycle.
  - aux_rvalid pulses 1 the cycle after an accepted aux read.
  - aux_rdata registers mem_rdata at acceptance and holds its value until the next accepted read.
- Back-to-back:
  - Aux reads while the CPU is idle are accepted every cycle; aux_rvalid stays high continuously.
  - With a continuous CPU stream, aux is guaranteed a grant within STARVE_LIMIT + 1 cycles of asserting aux_valid.
- Reset mid-operation:
  - Pending forced grant is discarded.
  - Any aux_rvalid in flight is dropped; the aux side must reissue the read.

Optional Feature:
- Macro ARB_STATS_EN.
- Defined:
  - stat_stalls increments each cycle cpu_stall = 1.
  - stat_aux increments on each aux handshake.
  - Both are 16-bit and saturate at 16'hFFFF (no wrap).
- Undefined: stat_stalls and stat_aux are tied to 0 and no counter flops are built.

Decomposition:
- Shared package (dmem_arb_pkg): arb_state_t enum {ARB_CPU, ARB_WAIT, ARB_FORCE}, DW/AW defaults, the STAT_W = 16 constant.
- One natural sub-module: arb_sat_counter (width parameter, inc, clear, saturating), used for starve_cnt and both stat counters.

Test Plan:
- Reset release, idle; aux write addr 8'h10 data 8'hA5 → aux_ready = 1 same cycle, mem_we = 1, mem_addr = 8'h10. Then aux read 8'h10 → aux_rvalid = 1 the next cycle with aux_rdata = 8'hA5.
- CPU store every cycle with aux_valid held, STARVE_LIMIT = 4:
  - aux_ready = 0 for 4 cycles, then 1 in cycle 5 with cpu_stall = 1.
  - CPU store lands the following cycle, checked in memory.
- CPU load of 8'h20 and aux read of 8'h21 in the same cycle, state ARB_CPU → CPU granted, cpu_stall = 0, mem_addr = 8'h20, aux_ready = 0.
- aux_valid dropped in ARB_WAIT after 2 cycles, then reasserted → starve_cnt restarts from 1; no stall until 4 more blocked cycles.
- reset asserted the cycle after an accepted aux read → aux_rvalid = 0 and state = ARB_CPU immediately (async).
- ARB_STATS_EN defined, 3 forced grants → stat_stalls = 3, stat_aux = 3. Preload stat_stalls to 16'hFFFF via force, add one more stall → it remains 16'hFFFF.
